// File: rtl/stage1_key_seq.sv
// stage1_key_seq: Stage 1 key-hunt sequencer; maps clicks to key progression,
// applies pickup cooldown and a frame-counted time limit, reports clear/fail.
module stage1_key_seq #(
    parameter int DOOR_X0    = 140,
    parameter int DOOR_X1    = 180,
    parameter int DOOR_Y0    = 100,
    parameter int DOOR_Y1    = 160,
    parameter int COOLDOWN   = 15,
    parameter int TIME_LIMIT = 3600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  state,
    input  logic        frame_tick,
    input  logic        click,
    input  logic [9:0]  mouse_x,
    input  logic [9:0]  mouse_y,
    output logic [1:0]  key_find,
    output logic        stage_clear,
    output logic        stage_fail,
    output logic [11:0] time_left
);
    localparam logic [3:0] STAGE1 = 4'd2;
    localparam int CW = $clog2(COOLDOWN + 2);

    typedef enum logic [2:0] {IDLE, SEEK1, SEEK2, SEEK3, DOOR, DONE} fsm_t;

    fsm_t          fsm;
    logic [CW-1:0] cooldown;
    logic [9:0]    px, py;
    logic          hit1, hit2, hit3, hit_door, target, go, final_tick, active;

    function automatic logic in_box(input logic [9:0] x, input logic [9:0] y,
                                    input int x0, input int x1, input int y0, input int y1);
        return int'(x) >= x0 && int'(x) < x1 && int'(y) >= y0 && int'(y) < y1;
    endfunction

    assign px         = {1'b0, mouse_x[9:1]};
    assign py         = {1'b0, mouse_y[9:1]};
    assign hit1       = in_box(px, py, 65, 85, 35, 55);
    assign hit2       = in_box(px, py, 235, 255, 35, 55);
    assign hit3       = in_box(px, py, 235, 255, 205, 225);
    assign hit_door   = in_box(px, py, DOOR_X0, DOOR_X1, DOOR_Y0, DOOR_Y1);
    assign target     = fsm == SEEK1 ? hit1 : fsm == SEEK2 ? hit2 : fsm == SEEK3 ? hit3 : 1'b0;
    assign go         = click && cooldown == '0;
    // a limit of 0 (or 1) means the very next tick expires the stage
    assign final_tick = frame_tick && time_left <= 12'd1;
    assign active     = fsm inside {SEEK1, SEEK2, SEEK3, DOOR};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= IDLE;
            key_find    <= 2'd0;
            stage_clear <= 1'b0;
            stage_fail  <= 1'b0;
            time_left   <= 12'(TIME_LIMIT);
            cooldown    <= '0;
        end else begin
            stage_clear <= 1'b0;
            stage_fail  <= 1'b0;
            if (frame_tick && cooldown != '0)
                cooldown <= cooldown - 1'b1;
            if (active && frame_tick && time_left != 12'd0)
                time_left <= time_left - 12'd1;
            case (fsm)
                IDLE: if (state == STAGE1) begin
                    fsm       <= SEEK1;
                    key_find  <= 2'd0;
                    time_left <= 12'(TIME_LIMIT);
                    cooldown  <= '0;
                end
                DONE: if (state != STAGE1) begin
                    fsm      <= IDLE;
                    key_find <= 2'd0;
                end
                default: begin
                    // priority: abort, then door clear (wins tie), then timeout (beats pickup)
                    if (state != STAGE1) begin
                        fsm      <= IDLE;
                        key_find <= 2'd0;
                    end else if (fsm == DOOR && go && hit_door) begin
                        fsm         <= DONE;
                        stage_clear <= 1'b1;
                    end else if (final_tick) begin
                        fsm        <= DONE;
                        stage_fail <= 1'b1;
                    end else if (go && target) begin
                        fsm      <= fsm_t'(fsm + 3'd1);
                        key_find <= key_find + 2'd1;
                        cooldown <= CW'(COOLDOWN);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stage1_key_seq.sv
// tb_stage1_key_seq: directed checks of the Stage 1 key sequencer
// (default instance plus a TIME_LIMIT=20 instance sharing the same stimulus).
module tb_stage1_key_seq;
    logic        clk, rst_n, frame_tick, click;
    logic [3:0]  state;
    logic [9:0]  mouse_x, mouse_y;
    logic [1:0]  kf, kf_t;
    logic        clr, fl, clr_t, fl_t;
    logic [11:0] tl, tl_t;
    int          checks = 0;
    int          failures = 0;

    stage1_key_seq dut (
        .clk(clk), .rst_n(rst_n), .state(state), .frame_tick(frame_tick), .click(click),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .key_find(kf), .stage_clear(clr),
        .stage_fail(fl), .time_left(tl)
    );

    stage1_key_seq #(.TIME_LIMIT(20)) dut_t (
        .clk(clk), .rst_n(rst_n), .state(state), .frame_tick(frame_tick), .click(click),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .key_find(kf_t), .stage_clear(clr_t),
        .stage_fail(fl_t), .time_left(tl_t)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // inputs change on the falling edge; outputs are read on the following falling edge
    task automatic step(input logic c, input logic t, input logic [9:0] x, input logic [9:0] y);
        click = c; frame_tick = t; mouse_x = x; mouse_y = y;
        @(negedge clk);
        click = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 10'd0, 10'd0);
    endtask

    task automatic enter_stage1();
        state = 4'd0; step(1'b0, 1'b0, 10'd0, 10'd0);
        state = 4'd2; step(1'b0, 1'b0, 10'd0, 10'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; state = 4'd0; click = 1'b0; frame_tick = 1'b0; mouse_x = '0; mouse_y = '0;
        #12 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (kf !== 2'd0) begin failures++; $display("FAIL reset_key key_find=%0d exp=0", kf); end
        checks++; if (tl !== 12'd3600) begin failures++; $display("FAIL reset_time time_left=%0d exp=3600", tl); end
        checks++; if (clr !== 1'b0 || fl !== 1'b0) begin failures++; $display("FAIL reset_pulses clear=%b fail=%b exp=0,0", clr, fl); end
        state = 4'd2; step(1'b0, 1'b0, 10'd0, 10'd0);
        checks++; if (kf !== 2'd0 || tl !== 12'd3600) begin failures++; $display("FAIL entry key_find=%0d time_left=%0d exp=0,3600", kf, tl); end
        checks++; if (tl_t !== 12'd20) begin failures++; $display("FAIL entry_short time_left=%0d exp=20", tl_t); end
        checks++; if (clr !== 1'b0 || fl !== 1'b0) begin failures++; $display("FAIL entry_pulses clear=%b fail=%b exp=0,0", clr, fl); end
    endtask

    task automatic test_edge_pixels();
        step(1'b1, 1'b0, 10'd170, 10'd90);
        checks++; if (kf !== 2'd0) begin failures++; $display("FAIL edge_px85 key_find=%0d exp=0", kf); end
        step(1'b1, 1'b0, 10'd168, 10'd90);
        checks++; if (kf !== 2'd1) begin failures++; $display("FAIL edge_px84 key_find=%0d exp=1", kf); end
    endtask

    task automatic test_cooldown();
        ticks(5);
        step(1'b1, 1'b0, 10'd480, 10'd90);
        checks++; if (kf !== 2'd1) begin failures++; $display("FAIL cooldown_block key_find=%0d exp=1", kf); end
        ticks(10);
        step(1'b1, 1'b0, 10'd10, 10'd10);
        checks++; if (kf !== 2'd1) begin failures++; $display("FAIL miss_click key_find=%0d exp=1", kf); end
        step(1'b1, 1'b0, 10'd150, 10'd90);
        checks++; if (kf !== 2'd1) begin failures++; $display("FAIL wrong_key key_find=%0d exp=1", kf); end
    endtask

    task automatic test_full_sequence();
        step(1'b1, 1'b0, 10'd480, 10'd90);
        checks++; if (kf !== 2'd2) begin failures++; $display("FAIL key2 key_find=%0d exp=2", kf); end
        ticks(15);
        step(1'b1, 1'b0, 10'd480, 10'd430);
        checks++; if (kf !== 2'd3) begin failures++; $display("FAIL key3 key_find=%0d exp=3", kf); end
        ticks(15);
        step(1'b1, 1'b0, 10'd320, 10'd260);
        checks++; if (clr !== 1'b1 || fl !== 1'b0) begin failures++; $display("FAIL door_clear clear=%b fail=%b exp=1,0", clr, fl); end
        step(1'b0, 1'b0, 10'd0, 10'd0);
        checks++; if (clr !== 1'b0) begin failures++; $display("FAIL clear_width clear=%b exp=0", clr); end
        checks++; if (tl !== 12'd3555) begin failures++; $display("FAIL done_time time_left=%0d exp=3555", tl); end
        ticks(3);
        checks++; if (tl !== 12'd3555 || kf !== 2'd3) begin failures++; $display("FAIL done_hold time_left=%0d key_find=%0d exp=3555,3", tl, kf); end
        step(1'b1, 1'b0, 10'd320, 10'd260);
        checks++; if (clr !== 1'b0) begin failures++; $display("FAIL done_reclick clear=%b exp=0", clr); end
    endtask

    task automatic test_abort();
        state = 4'd0; step(1'b0, 1'b0, 10'd0, 10'd0);
        checks++; if (kf !== 2'd0) begin failures++; $display("FAIL done_exit key_find=%0d exp=0", kf); end
        state = 4'd2; step(1'b0, 1'b0, 10'd0, 10'd0);
        step(1'b1, 1'b0, 10'd150, 10'd90);
        checks++; if (kf !== 2'd1) begin failures++; $display("FAIL key1_center key_find=%0d exp=1", kf); end
        ticks(15);
        step(1'b1, 1'b0, 10'd480, 10'd90);
        state = 4'd8; step(1'b0, 1'b0, 10'd0, 10'd0);
        checks++; if (kf !== 2'd0 || clr !== 1'b0 || fl !== 1'b0) begin failures++; $display("FAIL abort key_find=%0d clear=%b fail=%b exp=0,0,0", kf, clr, fl); end
        state = 4'd2; step(1'b0, 1'b0, 10'd0, 10'd0);
        checks++; if (tl !== 12'd3600 || kf !== 2'd0) begin failures++; $display("FAIL reentry time_left=%0d key_find=%0d exp=3600,0", tl, kf); end
    endtask

    task automatic test_tie();
        step(1'b1, 1'b0, 10'd150, 10'd90); ticks(15);
        step(1'b1, 1'b0, 10'd480, 10'd90); ticks(15);
        step(1'b1, 1'b0, 10'd480, 10'd430); ticks(15);
        checks++; if (kf !== 2'd3 || tl !== 12'd3555) begin failures++; $display("FAIL tie_setup key_find=%0d time_left=%0d exp=3,3555", kf, tl); end
        ticks(3554);
        checks++; if (tl !== 12'd1) begin failures++; $display("FAIL tie_pre time_left=%0d exp=1", tl); end
        step(1'b1, 1'b1, 10'd320, 10'd260);
        checks++; if (clr !== 1'b1 || fl !== 1'b0 || tl !== 12'd0) begin failures++; $display("FAIL tie clear=%b fail=%b time_left=%0d exp=1,0,0", clr, fl, tl); end
        step(1'b0, 1'b0, 10'd0, 10'd0);
        checks++; if (clr !== 1'b0 || fl !== 1'b0) begin failures++; $display("FAIL tie_after clear=%b fail=%b exp=0,0", clr, fl); end
    endtask

    task automatic test_timeout();
        enter_stage1();
        checks++; if (tl_t !== 12'd20) begin failures++; $display("FAIL to_entry time_left=%0d exp=20", tl_t); end
        ticks(19);
        checks++; if (tl_t !== 12'd1 || fl_t !== 1'b0) begin failures++; $display("FAIL to_pre time_left=%0d fail=%b exp=1,0", tl_t, fl_t); end
        ticks(1);
        checks++; if (fl_t !== 1'b1 || clr_t !== 1'b0 || tl_t !== 12'd0 || kf_t !== 2'd0) begin failures++; $display("FAIL timeout fail=%b clear=%b time_left=%0d key_find=%0d exp=1,0,0,0", fl_t, clr_t, tl_t, kf_t); end
        step(1'b0, 1'b0, 10'd0, 10'd0);
        checks++; if (fl_t !== 1'b0) begin failures++; $display("FAIL fail_width fail=%b exp=0", fl_t); end
        step(1'b1, 1'b0, 10'd150, 10'd90);
        ticks(2);
        checks++; if (kf_t !== 2'd0 || tl_t !== 12'd0 || fl_t !== 1'b0) begin failures++; $display("FAIL to_hold key_find=%0d time_left=%0d fail=%b exp=0,0,0", kf_t, tl_t, fl_t); end
    endtask

    task automatic test_fail_wins();
        enter_stage1();
        ticks(19);
        step(1'b1, 1'b1, 10'd150, 10'd90);
        checks++; if (fl_t !== 1'b1 || clr_t !== 1'b0 || kf_t !== 2'd0 || tl_t !== 12'd0) begin failures++; $display("FAIL fail_wins fail=%b clear=%b key_find=%0d time_left=%0d exp=1,0,0,0", fl_t, clr_t, kf_t, tl_t); end
    endtask

    initial begin
        test_reset();
        test_edge_pixels();
        test_cooldown();
        test_full_sequence();
        test_abort();
        test_tie();
        test_timeout();
        test_fail_wins();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
